reaction_game_ctrl: RTL
=======================

Name: reaction_game_ctrl

Overview:
Top-level sequencer for the reaction-time game. It issues the round-start pulse to the random generator and to count2rand, and waits for count2rand's get_rand pulse. It then lights the stimulus LED and measures the player's reaction in milliseconds. It flags early (foul) presses, timeouts and a running best time for the display path.

Parameters:
MAX_MS, 9999, reaction-time saturation/timeout value in ms.
WAIT_LIMIT, 6000, ms allowed in WAIT_RAND before aborting (guards a missing get_rand).
TW, 14, width of ms counters and result outputs (must hold max(MAX_MS, WAIT_LIMIT)).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick_ms  in  1  one-cycle 1 ms strobe, same tick that drives count2rand
start_btn  in  1  debounced one-cycle start press
react_btn  in  1  debounced one-cycle reaction press
get_rand  in  1  one-cycle pulse from count2rand
start_out  out  1  one-cycle round-start pulse to random generator and count2rand
led  out  1  stimulus light, high only in MEASURE
busy  out  1  high in WAIT_RAND and MEASURE
rt_ms  out  TW  last reaction time in ms, held until next valid result
rt_valid  out  1  one-cycle pulse when rt_ms updates
foul  out  1  level: early press in last round
timeout  out  1  level: no reaction (or no get_rand) in last round
best_ms  out  TW  minimum valid rt_ms since reset

Behaviour:
- Reset values: state IDLE; start_out=0, led=0, busy=0, rt_ms=0, rt_valid=0, foul=0, timeout=0, best_ms=MAX_MS; internal counter 0.
- States: IDLE, WAIT_RAND, MEASURE, DONE.
- start_btn in any state:
  - start_out=1 on the next cycle (registered, exactly 1 cycle).
  - Clear foul and timeout and the counter, then go to WAIT_RAND.
  - start_btn has priority over every other event in that cycle.
- WAIT_RAND (led=0):
  - react_btn: foul=1, go to DONE.
  - react_btn and get_rand in the same cycle: treated as a foul.
  - get_rand alone: clear the counter, go to MEASURE.
  - Counter counts tick_ms. When it reaches WAIT_LIMIT: timeout=1, go to DONE.
- MEASURE (led=1 from the cycle after get_rand):
  - Counter increments on each tick_ms, starting with ticks in the cycle after the get_rand cycle.
  - react_btn: rt_ms = counter value before this cycle's tick (a tick in the react cycle is not counted); rt_valid=1 for one cycle; go to DONE.
  - If rt_ms < best_ms, best_ms = rt_ms in the same cycle. Equal values do not update best_ms.
  - Counter reaching MAX_MS: timeout=1, go to DONE. rt_ms unchanged, no rt_valid, best_ms unchanged.
  - react_btn in the cycle the counter reaches MAX_MS: accepted as a valid rt_ms = MAX_MS-1 or MAX_MS per the counter rule above; no timeout is flagged.
- DONE / IDLE:
  - led=0, busy=0; react_btn and get_rand are ignored.
  - Results, foul and timeout are held until the next start_btn.
- Counter saturates and never wraps.
- Stray get_rand outside WAIT_RAND is ignored.
- rst asserted mid-round returns everything to reset values asynchronously. start_out never glitches high during or after reset.
- All outputs are registered.

Decomposition:
- Shared package reaction_pkg:
  - State enum (IDLE, WAIT_RAND, MEASURE, DONE).
  - TW, and the defaults for MAX_MS and WAIT_LIMIT.
  - Also the 5000 ms upper bound of the random range used by count2rand and the generator.
- One sub-module, ms_counter:
  - TW-bit counter with synchronous clear, enable = tick_ms, saturation at a limit input, and an at_limit flag.
  - Instantiated once and reused across WAIT_RAND and MEASURE.

Test Plan:
- Normal round: start_btn, get_rand 3000 ticks later, react_btn after 237 further tick_ms -> start_out 1-cycle pulse; led high for the measure window; rt_ms=237, rt_valid one pulse, best_ms=237.
- Early press: start_btn, react_btn before get_rand, then get_rand -> foul=1, led never high, rt_ms/best_ms unchanged, get_rand ignored.
- Simultaneous events:
  - react_btn and get_rand in the same cycle -> foul=1.
  - react_btn and tick_ms in the same cycle at counter 100 -> rt_ms=100.
- Timeouts:
  - No react for MAX_MS ticks -> timeout=1, no rt_valid, led drops.
  - No get_rand for WAIT_LIMIT ticks -> timeout=1, led never high.
- Best tracking: rounds of 300, 180, 250 ms -> best_ms 300, 180, 180.
- Restart and reset:
  - start_btn mid-MEASURE -> new start_out, led drops, counter restarts, flags cleared.
  - rst mid-MEASURE -> all outputs at reset values immediately; best_ms=9999.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game.
package reaction_pkg;

    // Default counter width; must hold max(MAX_MS_DEF, WAIT_LIMIT_DEF)
    localparam int TW_DEF         = 14;
    // Reaction-time saturation / no-response timeout, in ms
    localparam int MAX_MS_DEF     = 9999;
    // Longest wait for get_rand before the round is aborted, in ms
    localparam int WAIT_LIMIT_DEF = 6000;
    // Upper bound of the random delay produced by the generator/count2rand
    localparam int RAND_MAX_MS    = 5000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RAND = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/ms_counter.sv
// Millisecond counter: synchronous clear, tick enable, saturation at limit_i.
module ms_counter #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         at_limit_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins over tick; a tick at the limit leaves the count saturated
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q < limit_i)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign at_limit_o = (count_q >= limit_i);

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-game sequencer: start pulse, wait for get_rand, light LED,
// measure reaction in ms, flag foul/timeout and track the best time.
//
// Interface semantics: start_btn, react_btn, get_rand and tick_ms are
// one-cycle strobes sampled on the rising clock edge; there is no
// backpressure. start_out and rt_valid are one-cycle registered strobes;
// every other output is a registered level.
module reaction_game_ctrl
    import reaction_pkg::*;
#(
    parameter int MAX_MS     = MAX_MS_DEF,
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
    parameter int TW         = TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_ms,
    input  logic          start_btn,
    input  logic          react_btn,
    input  logic          get_rand,
    output logic          start_out,
    output logic          led,
    output logic          busy,
    output logic [TW-1:0] rt_ms,
    output logic          rt_valid,
    output logic          foul,
    output logic          timeout,
    output logic [TW-1:0] best_ms,
    output state_t        dbg_state_o
);

    localparam logic [TW-1:0] MAX_MS_V     = TW'(MAX_MS);
    localparam logic [TW-1:0] WAIT_LIMIT_V = TW'(WAIT_LIMIT);

    state_t        state_q;
    logic          start_out_q;
    logic          led_q;
    logic          busy_q;
    logic [TW-1:0] rt_ms_q;
    logic          rt_valid_q;
    logic          foul_q;
    logic          timeout_q;
    logic [TW-1:0] best_ms_q;

    logic          cnt_clr;
    logic          cnt_en;
    logic [TW-1:0] cnt_limit;
    logic [TW-1:0] cnt_val;
    logic          cnt_at_limit;

    // Counter control: one counter serves both the wait and the measure phase
    always_comb begin
        cnt_clr   = start_btn ||
                    ((state_q == WAIT_RAND) && get_rand && !react_btn);
        cnt_en    = tick_ms && ((state_q == WAIT_RAND) || (state_q == MEASURE));
        cnt_limit = (state_q == WAIT_RAND) ? WAIT_LIMIT_V : MAX_MS_V;
    end

    ms_counter #(
        .W (TW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .limit_i    (cnt_limit),
        .count_o    (cnt_val),
        .at_limit_o (cnt_at_limit)
    );

    // Round FSM with registered outputs; start_btn overrides every other event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_out_q <= 1'b0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            rt_ms_q     <= '0;
            rt_valid_q  <= 1'b0;
            foul_q      <= 1'b0;
            timeout_q   <= 1'b0;
            best_ms_q   <= MAX_MS_V;
        end else begin
            start_out_q <= start_btn;
            rt_valid_q  <= 1'b0;
            if (start_btn) begin
                state_q   <= WAIT_RAND;
                foul_q    <= 1'b0;
                timeout_q <= 1'b0;
                led_q     <= 1'b0;
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    WAIT_RAND: begin
                        if (react_btn) begin
                            // Press before the light, even together with get_rand
                            foul_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else if (get_rand) begin
                            led_q   <= 1'b1;
                            state_q <= MEASURE;
                        end else if (cnt_at_limit) begin
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= DONE;
                        end
                    end
                    MEASURE: begin
                        if (react_btn) begin
                            // Counter value before this cycle's tick is the result
                            rt_ms_q    <= cnt_val;
                            rt_valid_q <= 1'b1;
                            if (cnt_val < best_ms_q) begin
                                best_ms_q <= cnt_val;
                            end
                            led_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else if (cnt_at_limit) begin
                            timeout_q <= 1'b1;
                            led_q     <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= DONE;
                        end
                    end
                    default: begin
                        // IDLE and DONE hold results until the next start_btn
                    end
                endcase
            end
        end
    end

    assign start_out   = start_out_q;
    assign led         = led_q;
    assign busy        = busy_q;
    assign rt_ms       = rt_ms_q;
    assign rt_valid    = rt_valid_q;
    assign foul        = foul_q;
    assign timeout     = timeout_q;
    assign best_ms     = best_ms_q;
    assign dbg_state_o = state_q;

endmodule
